// File: rtl/bus_read_serializer_pkg.sv
// rtl/bus_read_serializer_pkg.sv - shared state encoding and parameter limits for the read serializer
package bus_read_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam int WORD_BITS          = 16;
   localparam int BIT_CLOCKS_MIN     = 8;
   localparam int BIT_CLOCKS_MAX     = 255;
   localparam int PREAMBLE_BITS_MIN  = 1;
   localparam int PREAMBLE_BITS_MAX  = 255;
   localparam int WORDS_PER_SEC_MIN  = 1;
   localparam int WORDS_PER_SEC_MAX  = 1023;

   function automatic bit params_legal(input int bit_clocks, input int pulse_clocks,
                                       input int preamble_bits, input int words);
      return (bit_clocks >= BIT_CLOCKS_MIN) && (bit_clocks <= BIT_CLOCKS_MAX) &&
             (pulse_clocks >= 1) && (pulse_clocks < bit_clocks) &&
             (preamble_bits >= PREAMBLE_BITS_MIN) && (preamble_bits <= PREAMBLE_BITS_MAX) &&
             (words >= WORDS_PER_SEC_MIN) && (words <= WORDS_PER_SEC_MAX);
   endfunction

endpackage

// File: rtl/bus_read_serializer_bit_cell_timer.sv
// rtl/bus_read_serializer_bit_cell_timer.sv - bit-cell timer with end-of-cell strobe and registered clock pulse
module bus_read_serializer_bit_cell_timer #(
   parameter int BIT_CLOCKS   = 28,
   parameter int PULSE_CLOCKS = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   input  logic run,
   output logic cell_end,
   output logic cell_pulse
);

   logic [7:0] timer;
   logic [7:0] timer_next;

   assign cell_end = (timer == 8'(BIT_CLOCKS - 1));

   always_comb begin
      timer_next = cell_end ? 8'd0 : timer + 8'd1;
   end

   // restart opens a fresh cell immediately, so the pulse is already high in its first clock
   always_ff @(posedge clock) begin
      if (reset) begin
         timer      <= '0;
         cell_pulse <= 1'b0;
      end else if (restart) begin
         timer      <= '0;
         cell_pulse <= 1'b1;
      end else if (!run) begin
         timer      <= '0;
         cell_pulse <= 1'b0;
      end else begin
         timer      <= timer_next;
         cell_pulse <= (timer_next < 8'(PULSE_CLOCKS));
      end
   end

endmodule

// File: rtl/bus_read_serializer.sv
// rtl/bus_read_serializer.sv - fetches sector words from SDRAM and serializes them into a bit-cell read stream
module bus_read_serializer
   import bus_read_serializer_pkg::*;
#(
   parameter int BIT_CLOCKS       = 28,
   parameter int PULSE_CLOCKS     = 4,
   parameter int PREAMBLE_BITS    = 32,
   parameter int WORDS_PER_SECTOR = 321
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        read_gate,
   input  logic        sector_start,
   input  logic [15:0] dram_readdata,
   input  logic        dram_readack,
   output logic        load_address_busread,
   output logic        dram_read_enbl_busread,
   output logic        read_clock_pulse,
   output logic        read_data_bit,
   output logic        sector_active,
   output logic        underrun_error,
   output logic [9:0]  words_sent
);

   localparam logic [7:0] PREAMBLE_LAST = 8'(PREAMBLE_BITS - 1);
   localparam logic [7:0] WORD_LAST     = 8'(WORD_BITS - 1);
   localparam logic [9:0] WORDS_TOTAL   = 10'(WORDS_PER_SECTOR);

   generate
      if (!params_legal(BIT_CLOCKS, PULSE_CLOCKS, PREAMBLE_BITS, WORDS_PER_SECTOR)) begin : g_bad_params
         $error("bus_read_serializer: parameter out of range");
      end
   endgenerate

   state_t      state, state_next;
   logic [7:0]  cell_count, cell_count_next;
   logic [15:0] shift_reg, shift_next;
   logic [15:0] buf_data, buf_data_next;
   logic        buf_valid, buf_valid_next;
   logic        req_pending, req_pending_next;
   logic [9:0]  fetch_count, fetch_count_next;
   logic [9:0]  words_sent_next;
   logic        load_next, enbl_next, bit_next, active_next, underrun_next;
   logic        start_word, accept, running, cell_end;

   assign accept  = sector_start && read_gate;
   assign running = (state_next == ST_PREAMBLE) || (state_next == ST_SYNC) || (state_next == ST_DATA);

   bus_read_serializer_bit_cell_timer #(
      .BIT_CLOCKS   (BIT_CLOCKS),
      .PULSE_CLOCKS (PULSE_CLOCKS)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .restart    (accept),
      .run        (running),
      .cell_end   (cell_end),
      .cell_pulse (read_clock_pulse)
   );

   always_comb begin
      state_next       = state;
      cell_count_next  = cell_count;
      shift_next       = shift_reg;
      buf_data_next    = buf_data;
      buf_valid_next   = buf_valid;
      req_pending_next = req_pending;
      fetch_count_next = fetch_count;
      words_sent_next  = words_sent;
      load_next        = 1'b0;
      enbl_next        = 1'b0;
      bit_next         = read_data_bit;
      active_next      = sector_active;
      underrun_next    = underrun_error;
      start_word       = 1'b0;

      // a new accept also aborts whatever sector is in flight
      if (accept) begin
         state_next       = ST_PREAMBLE;
         cell_count_next  = '0;
         shift_next       = '0;
         buf_valid_next   = 1'b0;
         req_pending_next = 1'b1;
         fetch_count_next = 10'd1;
         words_sent_next  = '0;
         load_next        = 1'b1;
         bit_next         = 1'b0;
         active_next      = 1'b1;
         underrun_next    = 1'b0;
      end else if (state != ST_IDLE && !read_gate) begin
         state_next       = ST_IDLE;
         cell_count_next  = '0;
         shift_next       = '0;
         buf_valid_next   = 1'b0;
         req_pending_next = 1'b0;
         fetch_count_next = '0;
         words_sent_next  = '0;
         bit_next         = 1'b0;
         active_next      = 1'b0;
         underrun_next    = 1'b0;
      end else begin
         case (state)
            ST_PREAMBLE, ST_SYNC, ST_DATA: begin
               if (dram_readack && req_pending) begin
                  buf_data_next    = dram_readdata;
                  buf_valid_next   = 1'b1;
                  req_pending_next = 1'b0;
               end else if (!buf_valid && !req_pending && fetch_count != WORDS_TOTAL) begin
                  enbl_next        = 1'b1;
                  req_pending_next = 1'b1;
                  fetch_count_next = fetch_count + 10'd1;
               end

               if (cell_end) begin
                  if (state == ST_PREAMBLE) begin
                     if (cell_count == PREAMBLE_LAST) begin
                        state_next      = ST_SYNC;
                        cell_count_next = '0;
                        bit_next        = 1'b1;
                     end else begin
                        cell_count_next = cell_count + 8'd1;
                     end
                  end else if (state == ST_SYNC) begin
                     state_next = ST_DATA;
                     start_word = 1'b1;
                  end else if (cell_count == WORD_LAST) begin
                     words_sent_next = words_sent + 10'd1;
                     if (words_sent_next == WORDS_TOTAL) begin
                        state_next  = ST_DONE;
                        shift_next  = '0;
                        bit_next    = 1'b0;
                        active_next = 1'b0;
                     end else begin
                        start_word = 1'b1;
                     end
                  end else begin
                     cell_count_next = cell_count + 8'd1;
                     shift_next      = {shift_reg[14:0], 1'b0};
                     bit_next        = shift_reg[14];
                  end
               end

               // an empty buffer at a word start sends a zero word; the late ack fills the next slot
               if (start_word) begin
                  cell_count_next = '0;
                  if (buf_valid) begin
                     shift_next     = buf_data;
                     bit_next       = buf_data[15];
                     buf_valid_next = 1'b0;
                  end else begin
                     shift_next    = '0;
                     bit_next      = 1'b0;
                     underrun_next = 1'b1;
                  end
               end
            end
            ST_DONE: state_next = ST_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state                  <= ST_IDLE;
         cell_count             <= '0;
         shift_reg              <= '0;
         buf_data               <= '0;
         buf_valid              <= 1'b0;
         req_pending            <= 1'b0;
         fetch_count            <= '0;
         words_sent             <= '0;
         load_address_busread   <= 1'b0;
         dram_read_enbl_busread <= 1'b0;
         read_data_bit          <= 1'b0;
         sector_active          <= 1'b0;
         underrun_error         <= 1'b0;
      end else begin
         state                  <= state_next;
         cell_count             <= cell_count_next;
         shift_reg              <= shift_next;
         buf_data               <= buf_data_next;
         buf_valid              <= buf_valid_next;
         req_pending            <= req_pending_next;
         fetch_count            <= fetch_count_next;
         words_sent             <= words_sent_next;
         load_address_busread   <= load_next;
         dram_read_enbl_busread <= enbl_next;
         read_data_bit          <= bit_next;
         sector_active          <= active_next;
         underrun_error         <= underrun_next;
      end
   end

endmodule

// File: doc/bus_read_serializer.md
Name: bus_read_serializer

Overview:
- Upstream requester and downstream consumer of the sdram_controller on the disk-read path.
- On each sector start under read gate, it loads the sector address into the controller and fetches sector words one at a time with a prefetch handshake.
- It serializes each 16-bit word MSB-first into a bit-cell stream: per-cell clock pulse plus data level, toward the drive bus read drivers.
- Emits preamble zeros and a sync '1' ahead of data; flags underrun when SDRAM data arrives late.

Parameters:
- BIT_CLOCKS, 28, master clocks per bit cell (40 MHz / 28 ≈ 1.43 MHz); legal range 8..255.
- PULSE_CLOCKS, 4, width of read_clock_pulse at the start of each cell; must be < BIT_CLOCKS.
- PREAMBLE_BITS, 32, zero cells before the sync cell; legal range 1..255.
- WORDS_PER_SECTOR, 321, data words per sector; legal range 1..1023.

Ports:
- clock  in  1  master clock 40 MHz
- reset  in  1  synchronous reset, active high
- read_gate  in  1  read enable from bus control; level
- sector_start  in  1  one-clock pulse at sector mark
- dram_readdata  in  16  word from sdram_controller; valid in the dram_readack cycle
- dram_readack  in  1  one-clock acknowledge of a read
- load_address_busread  out  1  one-clock pulse: controller latches sector/head/cylinder address and performs the first read
- dram_read_enbl_busread  out  1  one-clock pulse: read next sequential word
- read_clock_pulse  out  1  high for PULSE_CLOCKS at the start of every cell
- read_data_bit  out  1  cell data level, stable for the whole cell
- sector_active  out  1  high from PREAMBLE entry until DONE
- underrun_error  out  1  sticky until next accepted sector_start or reset
- words_sent  out  10  count of data words fully shifted in the current sector

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, word buffer empty, shift register 0. Reset mid-sector aborts immediately; no request pulses follow.
- Clock/reset: one clock domain, `clock`; `reset` is synchronous and active-high. All outputs are registered.
- IDLE: wait for sector_start & read_gate. sector_start without read_gate is ignored.
- Accept (cycle 0):
  - Cycle 1: load_address_busread=1 for exactly one clock.
  - Cycle 1: state PREAMBLE, sector_active=1, bit timer=0, words_sent=0, underrun cleared.
- Bit timer: counts 0..BIT_CLOCKS-1 and wraps; a cell boundary is the timer==0 cycle.
  - read_clock_pulse=1 while timer < PULSE_CLOCKS.
  - read_data_bit updates only at the cell boundary.
- PREAMBLE: PREAMBLE_BITS cells with data 0, then SYNC.
- SYNC: one cell with data 1, then DATA.
- Buffer handshake:
  - One-word buffer with a valid flag; the buffer loads on dram_readack.
  - While the buffer is empty and no request is outstanding, and more words remain to fetch, pulse dram_read_enbl_busread. The first word is requested by load_address_busread.
  - At most one request is outstanding. A readack with no request outstanding is ignored.
- DATA:
  - At the boundary of the first cell of each word, transfer buffer to shift register and clear valid; that frees the buffer for the next prefetch.
  - Shift out 16 cells MSB first.
  - words_sent increments at the end of each 16th cell.
  - After WORDS_PER_SECTOR words, go to DONE.
- Underrun: at a word-start boundary with the buffer empty:
  - set underrun_error and shift 16 zero cells instead;
  - the still-outstanding word, when acked, fills the buffer for the following word slot (no request is skipped or duplicated).
- DONE: sector_active=0, the clock pulse stops, read_data_bit=0; go to IDLE on the next clock.
- Abort conditions (checked every cycle, priority over all else):
  - read_gate=0 in any non-IDLE state → IDLE next clock; outputs are zeroed, the buffer is cleared, and an outstanding ack is discarded.
  - sector_start during an active sector → treated as abort plus a new accept in the same cycle (restart sequence, load pulse one clock later).
- Total fetch count is exactly WORDS_PER_SECTOR request pulses (load + enbl) per uninterrupted sector.

Decomposition:
- Shared package: the state encoding (IDLE, PREAMBLE, SYNC, DATA, DONE) and parameter range-check constants.
- One sub-module is natural: bit_cell_timer (timer, boundary strobe, pulse generation), reusable by the write-side deserializer.

Test Plan:
1. Nominal, small config: WORDS_PER_SECTOR=4, PREAMBLE_BITS=4, BIT_CLOCKS=28; model acks 3 clocks after each request with data 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF.
   - Required: load pulse at cycle 1, then 3 enbl pulses.
   - Required stream: 0000 1 then the 64 data bits MSB first; words_sent=4; underrun_error=0; 69 clock pulses each 4 clocks wide.
2. Late ack: second word acked 600 clocks after its request.
   - Required: word slot 2 transmitted as 16 zeros, underrun_error=1.
   - Required: late data appears in slot 3; total request pulses=4.
3. read_gate dropped mid-word 2 → next clock all outputs 0, state IDLE; a subsequent ack produces no output or request.
4. sector_start during DATA → restart: load pulse 1 clock later, words_sent=0, preamble restarts.
5. Reset asserted during SYNC → all outputs 0 the following cycle; sector_start without read_gate afterward → no load pulse.
6. Spurious dram_readack in IDLE with data 16'h1234 → ignored; the next sector transmits only its own fetched words.
